// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants for the elastic pipeline stages
// Contents:
//   ST_EMPTY/ST_FULL/ST_SKID  state encoding; each value equals the buffered-beat count
//   PIPE_WIDTH/PIPE_LANES     default lane width and lane count for all pipeline stages
//   pipe_state_t              2-bit state type
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam int PIPE_WIDTH = 32;
    localparam int PIPE_LANES = 2;

    typedef logic [1:0] pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - data register with synchronous clear and load enable
// Ports:
//   clk    in   rising-edge clock
//   clr_i  in   synchronous clear to zero; wins over load
//   ld_i   in   load d_i
//   d_i    in   DW-bit data in
//   q_o    out  DW-bit registered data
module pipe_slot #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline register with main + skid entries
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to add the stall_cycles counter port.
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset (priority over flush)
//   flush         in   discard all buffered beats this cycle
//   in_valid      in   upstream beat present
//   in_ready      out  stage can accept; function of registered state only
//   in_data       in   LANES*WIDTH beat, lane k = in_data[k*WIDTH +: WIDTH]
//   out_valid     out  beat presented downstream
//   out_ready     in   downstream accepts
//   out_data      out  main-entry data; zero while out_valid = 0
//   occupancy     out  buffered beats, 0..2
//   stall_cycles  out  (macro only) saturating count of out_valid & !out_ready cycles
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_WIDTH,
    parameter int LANES = PIPE_LANES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [1:0]             occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    localparam int DW = LANES * WIDTH;

    pipe_state_t   state_q;
    pipe_state_t   state_d;
    logic          in_xfer;
    logic          out_xfer;

    logic          main_clr;
    logic          main_ld;
    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;
    logic          skid_clr;
    logic          skid_ld;
    logic [DW-1:0] skid_q;

    // Handshake outputs come straight from the state register, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        if (reset || flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) state_d = ST_FULL;
                ST_FULL: begin
                    if (in_xfer && !out_xfer) begin
                        state_d = ST_SKID;
                    end else if (!in_xfer && out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID:  if (out_xfer) state_d = ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main entry is cleared whenever the stage drains to empty so that
    // out_data reads zero while out_valid is low.
    assign main_clr = reset | flush | ((state_q == ST_FULL) & out_xfer & ~in_xfer);
    assign main_ld  = ((state_q == ST_EMPTY) & in_xfer)
                    | ((state_q == ST_FULL)  & in_xfer & out_xfer)
                    | ((state_q == ST_SKID)  & out_xfer);
    assign main_d   = (state_q == ST_SKID) ? skid_q : in_data;

    // Skid entry only ever holds the second-oldest beat.
    assign skid_clr = reset | flush | ((state_q == ST_SKID) & out_xfer);
    assign skid_ld  = (state_q == ST_FULL) & in_xfer & ~out_xfer;

    pipe_slot #(.DW(DW)) u_main (
        .clk   (clk),
        .clr_i (main_clr),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_slot #(.DW(DW)) u_skid (
        .clk   (clk),
        .clr_i (skid_clr),
        .ld_i  (skid_ld),
        .d_i   (in_data),
        .q_o   (skid_q)
    );

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_q;

    // Flush deliberately does not clear the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - self-checking bench for pipe_stage_skid (PIPE_STAGE_STALL_CNT_EN optional)
module tb_pipe_stage_skid;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int DW = W * L;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic          rst;
        logic          fl;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [DW-1:0] d, logic ordy,
                                logic e_ir, logic e_ov, logic [DW-1:0] e_od, logic [1:0] e_occ);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic fl, logic iv, logic [DW-1:0] d, logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered list of buffered beats, at most two.
    logic [DW-1:0] mq[$];
    logic [31:0]   m_stall;

    initial begin
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);

        //        rst fl iv data      ordy  ir ov od        occ
        tbl.push_back(mk(1, 0, 1, 16'h5A5A, 0,  1, 0, 16'h0000, 2'd0)); // reset, in_valid high
        tbl.push_back(mk(1, 0, 1, 16'h5A5A, 0,  1, 0, 16'h0000, 2'd0));
        tbl.push_back(mk(0, 0, 1, 16'h2211, 1,  1, 1, 16'h2211, 2'd1)); // streaming
        tbl.push_back(mk(0, 0, 1, 16'h4433, 1,  1, 1, 16'h4433, 2'd1));
        tbl.push_back(mk(0, 0, 1, 16'h6655, 1,  1, 1, 16'h6655, 2'd1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 2'd0));
        tbl.push_back(mk(0, 0, 1, 16'hA1A0, 0,  1, 1, 16'hA1A0, 2'd1)); // back-pressure A
        tbl.push_back(mk(0, 0, 1, 16'hB1B0, 0,  0, 1, 16'hA1A0, 2'd2)); // B into skid
        tbl.push_back(mk(0, 0, 1, 16'hC1C0, 0,  0, 1, 16'hA1A0, 2'd2)); // C held upstream
        tbl.push_back(mk(0, 0, 1, 16'hC1C0, 1,  1, 1, 16'hB1B0, 2'd1)); // A out, B promoted
        tbl.push_back(mk(0, 0, 1, 16'hC1C0, 1,  1, 1, 16'hC1C0, 2'd1)); // B out, C in
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 2'd0)); // C out
        tbl.push_back(mk(0, 0, 1, 16'hD1D0, 0,  1, 1, 16'hD1D0, 2'd1)); // flush in SKID
        tbl.push_back(mk(0, 0, 1, 16'hE1E0, 0,  0, 1, 16'hD1D0, 2'd2));
        tbl.push_back(mk(0, 1, 1, 16'hF1F0, 0,  1, 0, 16'h0000, 2'd0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 2'd0)); // F never appears
        tbl.push_back(mk(0, 0, 1, 16'h0707, 0,  1, 1, 16'h0707, 2'd1)); // flush with in-transfer
        tbl.push_back(mk(0, 1, 1, 16'h0808, 1,  1, 0, 16'h0000, 2'd0));
        tbl.push_back(mk(0, 0, 1, 16'h0909, 0,  1, 1, 16'h0909, 2'd1)); // reset + flush together
        tbl.push_back(mk(0, 0, 1, 16'h0A0A, 0,  0, 1, 16'h0909, 2'd2));
        tbl.push_back(mk(1, 1, 1, 16'h0B0B, 0,  1, 0, 16'h0000, 2'd0));
        tbl.push_back(mk(0, 0, 1, 16'h0C0C, 1,  1, 1, 16'h0C0C, 2'd1));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            tick();
            chk($sformatf("tbl%0d in_ready", i),  {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
            chk($sformatf("tbl%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
            chk($sformatf("tbl%0d out_data", i),  {16'd0, out_data},  {16'd0, tbl[i].e_od});
            chk($sformatf("tbl%0d occupancy", i), {30'd0, occupancy}, {30'd0, tbl[i].e_occ});
        end

`ifdef PIPE_STAGE_STALL_CNT_EN
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0); tick();
        chk("stall after reset", stall_cycles, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, 1'b0); tick();
        end
        chk("stall 5 cycles", stall_cycles, 32'd5);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1); tick();
        chk("stall kept by flush", stall_cycles, 32'd5);
        chk("flush empties", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 16'h5678, 1'b0); tick();
        force dut.stall_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_q;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, '0, 1'b0); tick();
        end
        chk("stall saturates", stall_cycles, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 1'b1, '0, 1'b0); tick();
        chk("stall cleared by reset+flush", stall_cycles, 32'd0);
`endif

        // Randomized run against the queue model; first cycle is a reset.
        mq.delete();
        m_stall = '0;
        for (int c = 0; c < 3000; c++) begin
            logic rst, fl, iv, ordy, in_x, out_x;
            logic [DW-1:0] d;
            rst  = (c == 0) || ($urandom_range(0, 199) == 0);
            fl   = ($urandom_range(0, 39) == 0);
            iv   = ($urandom_range(0, 99) < 65);
            ordy = ($urandom_range(0, 99) < 60);
            d    = DW'($urandom);
            drive(rst, fl, iv, d, ordy);

            in_x  = iv && (mq.size() < 2);
            out_x = (mq.size() > 0) && ordy;
            if (rst) begin
                m_stall = '0;
            end else if ((mq.size() > 0) && !ordy && (m_stall != 32'hFFFF_FFFF)) begin
                m_stall = m_stall + 32'd1;
            end

            tick();

            if (rst || fl) begin
                mq.delete();
            end else begin
                if (out_x) void'(mq.pop_front());
                if (in_x) mq.push_back(d);
            end

            chk($sformatf("rnd%0d in_ready", c),  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
            chk($sformatf("rnd%0d out_valid", c), {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            chk($sformatf("rnd%0d out_data", c),  {16'd0, out_data},
                {16'd0, (mq.size() > 0) ? mq[0] : {DW{1'b0}}});
            chk($sformatf("rnd%0d occupancy", c), {30'd0, occupancy}, 32'(mq.size()));
`ifdef PIPE_STAGE_STALL_CNT_EN
            chk($sformatf("rnd%0d stall_cycles", c), stall_cycles, m_stall);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
